// File: rtl/gray_sequencer_if.sv
// Purpose: bundles the control and status signals of the Gray-code sequencer.
// Latency: none. This file only groups wires.
// Backpressure: none. The bus has no handshake; control levels are sampled every core cycle.
//
// Signals:
//   start    - request to begin a pass (sampled only in IDLE)
//   dir      - 0 = count up, 1 = count down (captured with start)
//   cont     - 1 = repeat passes until halted (captured with start)
//   halt     - abort the current pass
//   gray_out - current Gray code (registered)
//   bin_out  - binary index of the current code (registered)
//   step     - one-cycle pulse in the first cycle a new code is shown
//   busy     - high while a pass is running
//   done     - one-cycle pulse, coincident with step, when a pass completes
// The master modport drives the controls; the slave modport is the sequencer.
interface gray_sequencer_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic             dir;
    logic             cont;
    logic             halt;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             step;
    logic             busy;
    logic             done;

    modport master (
        output start, dir, cont, halt,
        input  gray_out, bin_out, step, busy, done
    );

    modport slave (
        input  start, dir, cont, halt,
        output gray_out, bin_out, step, busy, done
    );
endinterface

// File: rtl/gray_sequencer.sv
// Purpose: steps a WIDTH-bit Gray code through all 2^WIDTH values, holding each for DWELL cycles.
// Latency: RUN is entered one edge after start. The first code change comes DWELL cycles later, and a pass takes 2^WIDTH*DWELL cycles.
// Backpressure: none. Start is ignored while running; halt aborts at the next edge.
//
// Ports:
//   clk - clock; all state changes on the rising edge
//   rst - asynchronous, active-high reset
//   bus - gray_sequencer_if slave: start/dir/cont/halt in; gray_out/bin_out/step/busy/done out
module gray_sequencer #(
    parameter int WIDTH = 3,
    parameter int DWELL = 50
) (
    input  logic             clk,
    input  logic             rst,
    gray_sequencer_if.slave  bus
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    dwell_q;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             dir_q;
    logic             cont_q;
    logic             step_q;
    logic             done_q;

    logic             busy;
    logic             advance;
    logic             pass_end;
    logic [WIDTH-1:0] bin_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. halt beats a pass completion in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // halt is meaningless in IDLE, so start always wins here.
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.halt) begin
                    state_d = IDLE;
                end else if (pass_end && !cont_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and advance decode
    always_comb begin
        busy     = (state_q == RUN);
        advance  = busy && !bus.halt && (dwell_q == LAST);
        bin_nxt  = dir_q ? (bin_q - 1'b1) : (bin_q + 1'b1);
        // The code returning to 0 marks the 2^WIDTH-th advance of the pass.
        pass_end = advance && (bin_nxt == '0);
    end

    // Datapath: dwell counter, code registers, latched mode and pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q <= '0;
            bin_q   <= '0;
            gray_q  <= '0;
            dir_q   <= 1'b0;
            cont_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                dwell_q <= '0;
                bin_q   <= '0;
                gray_q  <= '0;
                if (bus.start) begin
                    dir_q  <= bus.dir;
                    cont_q <= bus.cont;
                end
            end else if (bus.halt) begin
                dwell_q <= '0;
                bin_q   <= '0;
                gray_q  <= '0;
            end else if (advance) begin
                dwell_q <= '0;
                bin_q   <= bin_nxt;
                gray_q  <= bin_nxt ^ (bin_nxt >> 1);
                step_q  <= 1'b1;
                done_q  <= pass_end;
            end else begin
                dwell_q <= dwell_q + CW'(1);
            end
        end
    end

    assign bus.gray_out = gray_q;
    assign bus.bin_out  = bin_q;
    assign bus.step     = step_q;
    assign bus.busy     = busy;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_gray_sequencer.sv
`timescale 1ns/1ps
module tb_gray_sequencer;
    localparam int WA = 3;
    localparam int DA = 50;
    localparam int WB = 4;
    localparam int DB = 1;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gray_sequencer_if #(.WIDTH(WA)) ifa ();
    gray_sequencer_if #(.WIDTH(WB)) ifb ();

    gray_sequencer #(.WIDTH(WA), .DWELL(DA)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    gray_sequencer #(.WIDTH(WB), .DWELL(DB)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // One expected code change: the cycle it should appear, and what is shown then.
    typedef struct {
        int unsigned stamp;
        int unsigned bin;
        int unsigned gray;
        bit          done;
        bit          busy;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model. Advance j (1-based) of a run entered at cycle t0 shows
    // at cycle t0 + j*dwell. Its index is +/-j modulo 2^w. Every 2^w-th
    // advance completes a pass, and busy then survives only in continuous mode.
    task automatic push_exp(input bit ib, input int unsigned t0, input bit d,
                            input bit c, input int n);
        int unsigned m;
        int unsigned dw;
        int unsigned k;
        exp_t        e;
        m  = ib ? (1 << WB) : (1 << WA);
        dw = ib ? DB : DA;
        for (int j = 1; j <= n; j++) begin
            k       = j % m;
            e.stamp = t0 + j * dw;
            e.bin   = d ? ((m - k) % m) : k;
            e.gray  = e.bin ^ (e.bin >> 1);
            e.done  = (k == 0);
            e.busy  = c || (k != 0);
            if (ib) sb_b.push_back(e);
            else    sb_a.push_back(e);
        end
    endtask

    task automatic monitor(input bit ib, input bit step, input bit done, input bit busy,
                           input int unsigned bin, input int unsigned gray);
        string p;
        exp_t  e;
        p = ib ? "b" : "a";
        check({p, "_gray_is_code_of_bin"}, gray, bin ^ (bin >> 1));
        check({p, "_done_only_with_step"}, done & ~step, 0);
        if (step) begin
            if ((ib ? sb_b.size() : sb_a.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected_step: step with bin=%0d, required no step (cycle %0d)",
                         p, bin, cyc);
            end else begin
                e = ib ? sb_b.pop_front() : sb_a.pop_front();
                check({p, "_step_cycle"}, cyc, e.stamp);
                check({p, "_bin"}, bin, e.bin);
                check({p, "_gray"}, gray, e.gray);
                check({p, "_done"}, done, e.done);
                check({p, "_busy_at_step"}, busy, e.busy);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            monitor(1'b0, ifa.step, ifa.done, ifa.busy, ifa.bin_out, ifa.gray_out);
            monitor(1'b1, ifb.step, ifb.done, ifb.busy, ifb.bin_out, ifb.gray_out);
        end
    end

    task automatic check_idle_a(input string tag);
        check({tag, "_busy"}, ifa.busy, 0);
        check({tag, "_bin"},  ifa.bin_out, 0);
        check({tag, "_gray"}, ifa.gray_out, 0);
    endtask

    // One run on instance A: n advances are expected. Without halt the run
    // ends by pass completion. With halt, the halt edge falls inside dwell
    // period n+1, or exactly on advance n+1 when coincide is set.
    task automatic run_a(input bit d, input bit c, input int n, input bit hlt, input bit coincide);
        int unsigned t0;
        int unsigned stop;
        @(posedge clk); #1;
        ifa.start = 1'b1;
        ifa.dir   = d;
        ifa.cont  = c;
        ifa.halt  = 1'($urandom_range(0, 1));
        t0 = cyc + 1;
        push_exp(1'b0, t0, d, c, n);
        if (hlt) stop = t0 + n * DA + (coincide ? DA : $urandom_range(1, DA - 1));
        else     stop = t0 + n * DA;
        @(posedge clk); #1;
        ifa.halt = 1'b0;
        @(negedge clk);
        check("a_busy_after_start", ifa.busy, 1);
        check("a_first_code_held", ifa.gray_out, 0);
        while (cyc < stop - 1) begin
            ifa.start = 1'($urandom_range(0, 1));
            ifa.dir   = 1'($urandom_range(0, 1));
            ifa.cont  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        if (hlt) ifa.halt = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        ifa.halt  = 1'b0;
        @(negedge clk);
        check_idle_a("a_end_of_run");
        if (hlt) begin
            check("a_halt_no_step", ifa.step, 0);
            check("a_halt_no_done", ifa.done, 0);
        end
        repeat (3) @(negedge clk);
        check("a_scoreboard_drained", sb_a.size(), 0);
        check_idle_a("a_stays_idle");
    endtask

    // Reset arriving while code 110 (index 4) is shown.
    task automatic reset_mid_a();
        int unsigned t0;
        int unsigned tr;
        @(posedge clk); #1;
        ifa.start = 1'b1;
        ifa.dir   = 1'b0;
        ifa.cont  = 1'b1;
        t0 = cyc + 1;
        push_exp(1'b0, t0, 1'b0, 1'b1, 4);
        tr = t0 + 4 * DA + $urandom_range(1, DA - 1);
        @(posedge clk); #1;
        while (cyc < tr) begin
            ifa.start = 1'($urandom_range(0, 1));
            ifa.dir   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        #2;
        check("a_gray_before_rst", ifa.gray_out, 3'b110);
        rst = 1'b1;
        #1;
        check("a_rst_async_gray", ifa.gray_out, 0);
        check("a_rst_async_bin", ifa.bin_out, 0);
        check("a_rst_async_step", ifa.step, 0);
        check("a_rst_async_busy", ifa.busy, 0);
        check("a_rst_async_done", ifa.done, 0);
        ifa.start = 1'b0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("a_idle_after_rst_busy", ifa.busy, 0);
        end
        check("a_rst_scoreboard_drained", sb_a.size(), 0);
    endtask

    task automatic run_b(input bit d);
        int unsigned t0;
        @(posedge clk); #1;
        ifb.start = 1'b1;
        ifb.dir   = d;
        ifb.cont  = 1'b0;
        t0 = cyc + 1;
        push_exp(1'b1, t0, d, 1'b0, 1 << WB);
        @(posedge clk); #1;
        ifb.start = 1'b0;
        while (cyc < t0 + (1 << WB) * DB + 2) @(posedge clk);
        @(negedge clk);
        check("b_busy_after_pass", ifb.busy, 0);
        check("b_scoreboard_drained", sb_b.size(), 0);
    endtask

    initial begin
        bit d;
        bit c;
        int n;
        rst       = 1'b1;
        ifa.start = 1'b0; ifa.dir = 1'b0; ifa.cont = 1'b0; ifa.halt = 1'b0;
        ifb.start = 1'b0; ifb.dir = 1'b0; ifb.cont = 1'b0; ifb.halt = 1'b0;
        #1;
        check("a_reset_gray", ifa.gray_out, 0);
        check("a_reset_bin", ifa.bin_out, 0);
        check("a_reset_step", ifa.step, 0);
        check("a_reset_busy", ifa.busy, 0);
        check("a_reset_done", ifa.done, 0);
        check("b_reset_busy", ifb.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle with halt toggling but no start
        for (int i = 0; i < 6; i++) begin
            ifa.halt = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("a_idle_no_start_busy", ifa.busy, 0);
        end
        ifa.halt = 1'b0;

        run_a(1'b0, 1'b0, 8, 1'b0, 1'b0);                       // up, single pass
        run_a(1'b1, 1'b0, 8, 1'b0, 1'b0);                       // down, single pass
        run_a(1'($urandom_range(0, 1)), 1'b1, 16 + $urandom_range(0, 7), 1'b1, 1'b0);
        run_a(1'($urandom_range(0, 1)), 1'b0, 7, 1'b1, 1'b1);   // halt on the final advance
        reset_mid_a();
        run_a(1'b0, 1'b0, 8, 1'b0, 1'b0);                       // latched cont must be gone

        for (int it = 0; it < 5; it++) begin
            d = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            if (c) begin
                n = $urandom_range(0, 20);
                run_a(d, c, n, 1'b1, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 1) == 1) begin
                run_a(d, c, 8, 1'b0, 1'b0);
            end else begin
                n = $urandom_range(0, 7);
                run_a(d, c, n, 1'b1, 1'($urandom_range(0, 1)));
            end
        end

        run_b(1'b0);
        run_b(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_sequencer.md
GRAY_SEQUENCER -- requirements
Module: gray_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the code width in bits (legal 2..16).
REQ-002 The block SHALL have parameter DWELL, default 50, giving the clock cycles each code is held (legal 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a pass, sampled in IDLE.
REQ-006 The block SHALL have port dir, input, 1 bit: 0 = count up, 1 = count down; sampled with start.
REQ-007 The block SHALL have port cont, input, 1 bit: 1 = repeat passes continuously; sampled with start.
REQ-008 The block SHALL have port halt, input, 1 bit: abort the current pass.
REQ-009 The block SHALL have port gray_out, output, WIDTH bits: the current Gray code, registered.
REQ-010 The block SHALL have port bin_out, output, WIDTH bits: the binary index of the current code, registered.
REQ-011 The block SHALL have port step, output, 1 bit: one-cycle pulse in the first cycle a new code is shown.
REQ-012 The block SHALL have port busy, output, 1 bit: 1 while in RUN.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-015 In IDLE, bin_out and gray_out SHALL be 0, busy SHALL be 0, and the dwell counter SHALL be 0.
REQ-016 In IDLE, start=1 SHALL move the FSM to RUN at the next edge, latching dir and cont for the whole run.
REQ-017 In RUN, start SHALL be ignored, and changes on dir or cont SHALL have no effect.
REQ-018 In RUN, the dwell counter SHALL count 0..DWELL-1; at the edge where it equals DWELL-1 it SHALL return to 0 and the code SHALL advance.
REQ-019 On an advance, bin_out SHALL become bin_out+1 (dir=0) or bin_out-1 (dir=1), modulo 2^WIDTH.
REQ-020 gray_out SHALL always equal bin_out XOR (bin_out >> 1), updated on the same edge as bin_out.
REQ-021 step SHALL be 1 exactly in the cycle after each advance edge, and 0 otherwise.
REQ-022 Consecutive gray_out values, including the wrap to 0, SHALL differ in exactly one bit.
REQ-023 A pass SHALL be complete on the advance that returns bin_out to 0, which is the 2^WIDTH-th advance after entering RUN.
REQ-024 On pass completion, done SHALL pulse together with step.
REQ-025 On pass completion with latched cont=0, the FSM SHALL go to IDLE at that edge.
REQ-026 On pass completion with latched cont=1, the FSM SHALL stay in RUN and continue immediately.
REQ-027 The first code change SHALL occur DWELL cycles after entering RUN, and one pass SHALL last exactly 2^WIDTH*DWELL cycles.
REQ-028 halt=1 in RUN SHALL force IDLE at the next edge, with bin, gray, and dwell counter cleared and no done or step pulse.
REQ-029 halt SHALL take priority over an advance or pass completion in the same cycle.
REQ-030 halt SHALL have no effect in IDLE.
REQ-031 When start=1 and halt=1 arrive in IDLE in the same cycle, start SHALL win.

Reset
REQ-032 rst=1 SHALL immediately, without a clock, force IDLE, gray_out=0, bin_out=0, step=0, busy=0, done=0, and dwell counter=0.
REQ-033 After rst deasserts, the block SHALL remain in IDLE until start is asserted.
REQ-034 Reset asserted mid-pass SHALL discard the latched dir and cont.

Verification
REQ-035 WIDTH=3, DWELL=50, dir=0, cont=0, start pulse -> gray_out 000,001,011,010,110,111,101,100,000, each held 50 cycles; done pulses once, 400 cycles after entering RUN; busy then falls.
REQ-036 Same configuration with dir=1 -> gray_out 000,100,101,111,110,010,011,001,000; bin_out 0,7,6,5,4,3,2,1,0.
REQ-037 cont=1 -> done pulses every 400 cycles with busy held at 1; then halt=1 -> next cycle IDLE, outputs 0, no done.
REQ-038 rst pulsed while gray_out=110 -> all outputs 0 before the next clock edge; start is then required to restart.
REQ-039 WIDTH=4, DWELL=1 -> step every cycle; 16 codes, each one bit from the previous; done at cycle 16.
REQ-040 start asserted during RUN -> ignored; halt coincident with the final advance -> IDLE with no done pulse.
